// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA timing decoder:
//   - reference 640x480@60 mode constants (totals derived from the porches)
//   - measurement counter and coordinate widths
//   - lock FSM state encoding
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing of the reference mode, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing of the reference mode, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    // Measurement counters and pixel coordinates
    localparam int CNT_W = 12;
    localparam int PIX_W = 10;

    // Lock state machine
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_pulse_meter.sv
// ----------------------------------------------------------------------------
// sync_pulse_meter
//   Measures one sync pulse stream: the period between successive active
//   edges and the width of the active phase, both in units of count_en.
//
// Ports
//   i_clk       pixel clock
//   i_reset     synchronous active-high reset
//   i_pulse     polarity-normalised sync (1 = active), already registered once
//   i_count_en  counting qualifier (1 for clocks, h active edge for lines)
//   o_period    last measured active-edge to active-edge period
//   o_width     last measured active width
//   o_meas      running measurement including the current cycle; this is the
//               value that o_period/o_width take on the corresponding edge
//   o_act_edge  inactive->active transition this cycle
//   o_end_edge  active->inactive transition this cycle
// ----------------------------------------------------------------------------
module sync_pulse_meter
    import vga_timing_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pulse,
    input  logic             i_count_en,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_meas,
    output logic             o_act_edge,
    output logic             o_end_edge
);

    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             en);
        if (en && (val != {CNT_W{1'b1}})) begin
            return val + 1'b1;
        end
        return val;
    endfunction

    assign o_act_edge = i_pulse & ~r_prev;
    assign o_end_edge = ~i_pulse & r_prev;

    // The counter holds units elapsed before this cycle; adding this cycle's
    // qualifier lets a line that closes on the same cycle as a vsync edge
    // still be counted in the frame it belongs to.
    assign o_meas = sat_inc(r_cnt, i_count_en);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev   <= 1'b0;
            r_cnt    <= '0;
            o_period <= '0;
            o_width  <= '0;
        end else begin
            r_prev <= i_pulse;
            r_cnt  <= o_act_edge ? '0 : o_meas;
            if (o_act_edge) begin
                o_period <= o_meas;
            end
            if (o_end_edge) begin
                o_width <= o_meas;
            end
        end
    end

endmodule

// File: rtl/vga_timing_decoder.sv
// ----------------------------------------------------------------------------
// vga_timing_decoder
//   Receive-side VGA timing checker. Samples h_sync / v_sync / display_en on
//   the pixel clock, measures line and frame timing, compares it against the
//   expected mode and reports lock. Also regenerates per-pixel coordinates
//   aligned two clocks behind display_en, independent of lock.
//
// Ports
//   i_clk          pixel clock
//   i_reset        synchronous active-high reset
//   i_h_sync       horizontal sync (active level H_POL)
//   i_v_sync       vertical sync (active level V_POL)
//   i_display_en   active-video flag
//   o_locked       timing has matched the parameters for LOCK_FRAMES frames
//   o_err          one-cycle pulse on a timing mismatch while locked
//   o_pix_valid    display_en delayed by two clocks
//   o_pix_x        column within the active line, 0 when not valid
//   o_pix_y        active line index within the frame
//   o_line_len     last measured hsync period (clocks)
//   o_hsync_width  last measured hsync active width (clocks)
//   o_frame_lines  last measured vsync period (lines)
//   o_vsync_width  last measured vsync active width (lines)
// ----------------------------------------------------------------------------
module vga_timing_decoder #(
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC_W    = vga_timing_pkg::H_SYNC,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC_W    = vga_timing_pkg::V_SYNC,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_display_en,
    output logic        o_locked,
    output logic        o_err,
    output logic        o_pix_valid,
    output logic [9:0]  o_pix_x,
    output logic [9:0]  o_pix_y,
    output logic [11:0] o_line_len,
    output logic [11:0] o_hsync_width,
    output logic [11:0] o_frame_lines,
    output logic [11:0] o_vsync_width
);

    import vga_timing_pkg::*;

    // Expected values, zero-extended to the counter width
    localparam logic [CNT_W-1:0] EXP_HT      = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] EXP_HSW     = CNT_W'(H_SYNC_W);
    localparam logic [CNT_W-1:0] EXP_VT      = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] EXP_VSW     = CNT_W'(V_SYNC_W);
    localparam logic [CNT_W-1:0] EXP_TIMEOUT = CNT_W'(2 * H_TOTAL);
    localparam logic [7:0]       LOCK_CNT    = 8'(LOCK_FRAMES);

    // ---------------- input stage (s1) ----------------
    logic r_hs_s1;
    logic r_vs_s1;
    logic r_de_s1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Park the sync registers at their inactive level so that leaving
            // reset does not look like a sync edge.
            r_hs_s1 <= ~H_POL;
            r_vs_s1 <= ~V_POL;
            r_de_s1 <= 1'b0;
        end else begin
            r_hs_s1 <= i_h_sync;
            r_vs_s1 <= i_v_sync;
            r_de_s1 <= i_display_en;
        end
    end

    // Normalised syncs: 1 means active regardless of polarity
    logic w_hs_n;
    logic w_vs_n;

    assign w_hs_n = ~(r_hs_s1 ^ H_POL);
    assign w_vs_n = ~(r_vs_s1 ^ V_POL);

    // ---------------- measurement ----------------
    logic [CNT_W-1:0] w_h_meas;
    logic [CNT_W-1:0] w_v_meas;
    logic             w_h_act;
    logic             w_h_end;
    logic             w_v_act;
    logic             w_v_end;

    sync_pulse_meter u_hmeter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_pulse    (w_hs_n),
        .i_count_en (1'b1),
        .o_period   (o_line_len),
        .o_width    (o_hsync_width),
        .o_meas     (w_h_meas),
        .o_act_edge (w_h_act),
        .o_end_edge (w_h_end)
    );

    // Lines are counted by hsync active edges
    sync_pulse_meter u_vmeter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_pulse    (w_vs_n),
        .i_count_en (w_h_act),
        .o_period   (o_frame_lines),
        .o_width    (o_vsync_width),
        .o_meas     (w_v_meas),
        .o_act_edge (w_v_act),
        .o_end_edge (w_v_end)
    );

    // ---------------- timing comparison ----------------
    // At a vsync active edge the frame length is the running measurement;
    // the other three figures are the latched ones from earlier in the frame.
    logic w_frame_ok;
    logic w_lock_mismatch;
    logic w_timeout;

    assign w_frame_ok = (o_line_len    == EXP_HT)  &&
                        (o_hsync_width == EXP_HSW) &&
                        (w_v_meas      == EXP_VT)  &&
                        (o_vsync_width == EXP_VSW);

    // While locked each figure is checked on the edge that completes it
    assign w_lock_mismatch = (w_h_act && (w_h_meas != EXP_HT))  ||
                             (w_h_end && (w_h_meas != EXP_HSW)) ||
                             (w_v_act && (w_v_meas != EXP_VT))  ||
                             (w_v_end && (w_v_meas != EXP_VSW));

    // h measurement counts clocks since the last hsync active edge
    assign w_timeout = ~w_h_act && (w_h_meas >= EXP_TIMEOUT);

    // ---------------- lock FSM ----------------
    state_t     r_state;
    logic [7:0] r_match_cnt;
    logic [7:0] w_match_next;

    assign w_match_next = r_match_cnt + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            o_err       <= 1'b0;
            o_locked    <= 1'b0;
        end else begin
            o_err    <= 1'b0;
            // locked follows the state one cycle later, so on a mismatch the
            // err pulse comes first and locked drops on the next cycle
            o_locked <= (r_state == LOCKED);

            if (w_timeout) begin
                r_state     <= SEARCH;
                r_match_cnt <= '0;
            end else begin
                case (r_state)
                    SEARCH: begin
                        if (w_v_act) begin
                            r_state     <= MEASURE;
                            r_match_cnt <= '0;
                        end
                    end
                    MEASURE: begin
                        if (w_v_act) begin
                            if (w_frame_ok) begin
                                r_match_cnt <= w_match_next;
                                if (w_match_next >= LOCK_CNT) begin
                                    r_state <= LOCKED;
                                end
                            end else begin
                                r_match_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_lock_mismatch) begin
                            o_err       <= 1'b1;
                            r_state     <= SEARCH;
                            r_match_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state     <= SEARCH;
                        r_match_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------- coordinates (s2 / output) ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pix_valid <= 1'b0;
            o_pix_x     <= '0;
            o_pix_y     <= '0;
        end else begin
            o_pix_valid <= r_de_s1;

            // First pixel of a run gets 0, following pixels count up
            if (r_de_s1) begin
                o_pix_x <= o_pix_valid ? (o_pix_x + 10'd1) : 10'd0;
            end else begin
                o_pix_x <= '0;
            end

            // Row advances when the delayed DE falls; frame start wins
            if (w_v_act) begin
                o_pix_y <= '0;
            end else if (!r_de_s1 && o_pix_valid) begin
                o_pix_y <= o_pix_y + 10'd1;
            end
        end
    end

endmodule
